// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding selects, load-use / branch /
// divider / HI-LO stall detection, exception redirect and flush control,
// a multi-cycle divider occupancy FSM and a saturating stall-cycle counter.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   rsD, rtD, branchD, balD,
//   hiloreadD                 decode-stage sources and controls
//   forwardaD, forwardbD      decode forward selects (01 = E, 10 = M)
//   rsE, rtE, rdE, writeregE,
//   regwriteE, memtoregE,
//   div_startE                execute-stage fields and controls
//   forwardaE, forwardbE,
//   forwardhE, forwardcp0E    execute forward selects (10 = M, 01 = W)
//   writeregM/W, *writeM/W    later-stage destinations and write enables
//   excepttypeM, cp0_epcM     exception code and saved EPC
//   newpcM, newpc_validM      exception redirect target and strobe
//   stall*/flush*             pipeline stall and flush controls
//   div_busy, stall_cnt       divider occupied, saturating stall count
module hazard_scoreboard #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DIV_LAT = 32,
  parameter logic [31:0] EXC_VEC = 32'hBFC00380,
  parameter int unsigned CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rsD,
  input  logic [AW-1:0]   rtD,
  input  logic            branchD,
  input  logic            balD,
  input  logic            hiloreadD,
  output logic [1:0]      forwardaD,
  output logic [1:0]      forwardbD,
  input  logic [AW-1:0]   rsE,
  input  logic [AW-1:0]   rtE,
  input  logic [AW-1:0]   rdE,
  input  logic [AW-1:0]   writeregE,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic            div_startE,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic [1:0]      forwardhE,
  output logic [1:0]      forwardcp0E,
  input  logic [AW-1:0]   writeregM,
  input  logic [AW-1:0]   writeregW,
  input  logic            regwriteM,
  input  logic            memtoregM,
  input  logic            hilowriteM,
  input  logic            cp0writeM,
  input  logic            regwriteW,
  input  logic            hilowriteW,
  input  logic            cp0writeW,
  input  logic [31:0]     excepttypeM,
  input  logic [31:0]     cp0_epcM,
  output logic [31:0]     newpcM,
  output logic            newpc_validM,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushF,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic            div_busy,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_LAT - 1);

  div_state_t state, state_n;
  logic [7:0] count, count_n;
  logic       exc, lwstall, branchstall, divstall, hilostall;

  function automatic logic [1:0] fwd_d(input logic [AW-1:0] src);
    if (src != '0 && src == writeregE && regwriteE)      fwd_d = 2'b01;
    else if (src != '0 && src == writeregM && regwriteM) fwd_d = 2'b10;
    else                                                 fwd_d = 2'b00;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [AW-1:0] src, input logic wm,
                                       input logic ww);
    if (src != '0 && src == writeregM && wm)      fwd_e = 2'b10;
    else if (src != '0 && src == writeregW && ww) fwd_e = 2'b01;
    else                                          fwd_e = 2'b00;
  endfunction

  always_comb begin
    forwardaD   = fwd_d(rsD);
    forwardbD   = fwd_d(rtD);
    forwardaE   = fwd_e(rsE, regwriteM, regwriteW);
    forwardbE   = fwd_e(rtE, regwriteM, regwriteW);
    forwardcp0E = fwd_e(rdE, cp0writeM, cp0writeW);
    forwardhE   = hilowriteM ? 2'b10 : (hilowriteW ? 2'b01 : 2'b00);
  end

  always_comb begin
    exc          = excepttypeM != '0;
    newpc_validM = exc;
    if (!exc)                       newpcM = '0;
    else if (excepttypeM == 32'h0E) newpcM = cp0_epcM;
    else                            newpcM = EXC_VEC;

    lwstall     = memtoregE && writeregE != '0 &&
                  (writeregE == rsD || writeregE == rtD);
    branchstall = branchD &&
                  ((regwriteE && writeregE != '0 && (writeregE == rsD || writeregE == rtD)) ||
                   (memtoregM && writeregM != '0 && (writeregM == rsD || writeregM == rtD)));
    divstall    = (state == BUSY) || (state == IDLE && div_startE);
    div_busy    = (state == BUSY) || (state == DONE);
    hilostall   = hiloreadD && (div_busy || div_startE);

    stallF = (lwstall || branchstall || divstall || hilostall) && !balD && !exc;
    stallD = stallF;
    stallE = divstall && !exc;
    flushF = exc;
    flushD = exc;
    flushM = exc;
    flushW = exc;
    flushE = exc || ((lwstall || branchstall || hilostall) && !balD && !stallE);
  end

  // The count is loaded with DIV_LAT-1 and the FSM leaves BUSY on the cycle
  // the count steps down to zero, so a start plus BUSY spans DIV_LAT cycles.
  always_comb begin
    state_n = state;
    count_n = count;
    unique case (state)
      IDLE: if (div_startE) begin
        state_n = BUSY;
        count_n = DIV_LOAD;
      end
      BUSY: if (count <= 8'd1) begin
        state_n = DONE;
        count_n = '0;
      end else begin
        count_n = count - 8'd1;
      end
      DONE: state_n = IDLE;
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
    if (exc) begin
      state_n = IDLE;
      count_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (stallF && stall_cnt != '1) stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int unsigned AW = 5;
  localparam int unsigned CNTW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, writeregW;
  logic branchD, balD, hiloreadD, regwriteE, memtoregE, div_startE;
  logic regwriteM, memtoregM, hilowriteM, cp0writeM, regwriteW, hilowriteW, cp0writeW;
  logic [31:0] excepttypeM, cp0_epcM, newpcM;
  logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE, forwardhE, forwardcp0E;
  logic newpc_validM, stallF, stallD, stallE, flushF, flushD, flushE, flushM, flushW;
  logic div_busy;
  logic [CNTW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(AW), .DIV_LAT(4), .EXC_VEC(32'hBFC00380), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .balD(balD),
    .hiloreadD(hiloreadD), .forwardaD(forwardaD), .forwardbD(forwardbD),
    .rsE(rsE), .rtE(rtE), .rdE(rdE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .div_startE(div_startE), .forwardaE(forwardaE),
    .forwardbE(forwardbE), .forwardhE(forwardhE), .forwardcp0E(forwardcp0E),
    .writeregM(writeregM), .writeregW(writeregW), .regwriteM(regwriteM),
    .memtoregM(memtoregM), .hilowriteM(hilowriteM), .cp0writeM(cp0writeM),
    .regwriteW(regwriteW), .hilowriteW(hilowriteW), .cp0writeW(cp0writeW),
    .excepttypeM(excepttypeM), .cp0_epcM(cp0_epcM), .newpcM(newpcM),
    .newpc_validM(newpc_validM), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .flushW(flushW), .div_busy(div_busy), .stall_cnt(stall_cnt)
  );

  localparam int unsigned FAD = 0, FBD = 1, FAE = 2, FBE = 3, FH = 4, FCP = 5,
    NPC = 6, NPV = 7, STF = 8, STD = 9, STE = 10, FLF = 11, FLD = 12, FLE = 13,
    FLM = 14, FLW = 15, BSY = 16, CNT = 17;

  typedef struct {
    string       tag;
    int unsigned id;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int unsigned pass_cnt = 0;
  int unsigned total = 0;

  function automatic logic [31:0] obs(input int unsigned id);
    case (id)
      FAD: obs = {30'b0, forwardaD};
      FBD: obs = {30'b0, forwardbD};
      FAE: obs = {30'b0, forwardaE};
      FBE: obs = {30'b0, forwardbE};
      FH:  obs = {30'b0, forwardhE};
      FCP: obs = {30'b0, forwardcp0E};
      NPC: obs = newpcM;
      NPV: obs = {31'b0, newpc_validM};
      STF: obs = {31'b0, stallF};
      STD: obs = {31'b0, stallD};
      STE: obs = {31'b0, stallE};
      FLF: obs = {31'b0, flushF};
      FLD: obs = {31'b0, flushD};
      FLE: obs = {31'b0, flushE};
      FLM: obs = {31'b0, flushM};
      FLW: obs = {31'b0, flushW};
      BSY: obs = {31'b0, div_busy};
      CNT: obs = {28'b0, stall_cnt};
      default: obs = 'x;
    endcase
  endfunction

  task automatic want(input string tag, input int unsigned id, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.id);
      total++;
      assert (o === e.exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    {rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, writeregW} = '0;
    {branchD, balD, hiloreadD, regwriteE, memtoregE, div_startE} = '0;
    {regwriteM, memtoregM, hilowriteM, cp0writeM, regwriteW, hilowriteW, cp0writeW} = '0;
    excepttypeM = '0;
    cp0_epcM    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr_inputs();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clr_inputs();
    want("rst_busy", BSY, 0); want("rst_cnt", CNT, 0); want("rst_npv", NPV, 0);
    want("rst_npc", NPC, 0); want("rst_stf", STF, 0); want("rst_fle", FLE, 0);
    check_all();
    tick();
    rst = 1'b1;

    // decode forwarding: E has priority over M
    rsD = 3; rtD = 3; writeregE = 3; regwriteE = 1; writeregM = 3; regwriteM = 1;
    rsE = 0; writeregW = 0; regwriteW = 1;
    want("fad_e", FAD, 2'b01); want("fbd_e", FBD, 2'b01); want("fae_r0", FAE, 2'b00);
    check_all();
    regwriteE = 0;
    want("fad_m", FAD, 2'b10);
    check_all();
    rsD = 0;
    want("fad_r0", FAD, 2'b00);
    check_all();

    // execute forwarding
    clr_inputs();
    rsE = 4; rtE = 4; writeregM = 4; regwriteM = 1; writeregW = 4; regwriteW = 1;
    want("fae_m", FAE, 2'b10); want("fbe_m", FBE, 2'b10);
    check_all();
    regwriteM = 0;
    want("fae_w", FAE, 2'b01);
    check_all();
    hilowriteM = 1; hilowriteW = 1;
    want("fh_m", FH, 2'b10);
    check_all();
    hilowriteM = 0;
    want("fh_w", FH, 2'b01);
    check_all();
    rdE = 12; writeregM = 12; cp0writeM = 1; writeregW = 12; cp0writeW = 1;
    want("fcp_m", FCP, 2'b10);
    check_all();
    cp0writeM = 0;
    want("fcp_w", FCP, 2'b01);
    check_all();
    rdE = 0;
    want("fcp_r0", FCP, 2'b00);
    check_all();

    // load-use and branch stalls
    clr_inputs();
    memtoregE = 1; writeregE = 5; rtD = 5;
    want("lw_stf", STF, 1); want("lw_std", STD, 1); want("lw_fle", FLE, 1);
    want("lw_ste", STE, 0);
    check_all();
    balD = 1;
    want("bal_stf", STF, 0); want("bal_std", STD, 0); want("bal_fle", FLE, 0);
    check_all();
    balD = 0; writeregE = 0; rtD = 0;
    want("lw_r0_stf", STF, 0);
    check_all();
    clr_inputs();
    branchD = 1; regwriteE = 1; writeregE = 6; rsD = 6;
    want("br_e_stf", STF, 1); want("br_e_fle", FLE, 1);
    check_all();
    regwriteE = 0; memtoregM = 1; writeregM = 6;
    want("br_m_stf", STF, 1);
    check_all();
    branchD = 0;
    want("nobr_stf", STF, 0);
    check_all();

    // divider window with DIV_LAT=4
    do_reset();
    div_startE = 1;
    want("div0_ste", STE, 1); want("div0_busy", BSY, 0);
    check_all();
    tick();
    div_startE = 0; hiloreadD = 1;
    for (int i = 0; i < 3; i++) begin
      want($sformatf("divB%0d_ste", i), STE, 1);
      want($sformatf("divB%0d_busy", i), BSY, 1);
      want($sformatf("divB%0d_std", i), STD, 1);
      want($sformatf("divB%0d_fle", i), FLE, 0);
      check_all();
      tick();
    end
    want("divD_ste", STE, 0); want("divD_busy", BSY, 1);
    want("divD_hilo_stf", STF, 1); want("divD_hilo_fle", FLE, 1);
    check_all();
    tick();
    want("divI_busy", BSY, 0); want("divI_stf", STF, 0);
    check_all();
    hiloreadD = 0;

    // exception redirect and flushes, with a load-use stall also pending
    memtoregE = 1; writeregE = 5; rtD = 5;
    excepttypeM = 32'h0E; cp0_epcM = 32'h80001234;
    want("eret_npc", NPC, 32'h80001234); want("eret_npv", NPV, 1);
    want("exc_flf", FLF, 1); want("exc_fld", FLD, 1); want("exc_fle", FLE, 1);
    want("exc_flm", FLM, 1); want("exc_flw", FLW, 1);
    want("exc_stf", STF, 0); want("exc_std", STD, 0); want("exc_ste", STE, 0);
    check_all();
    excepttypeM = 32'h08;
    want("exc_vec", NPC, 32'hBFC00380);
    check_all();
    clr_inputs();

    // exception aborts divide at BUSY count 2
    div_startE = 1;
    tick();
    div_startE = 0;
    tick();
    excepttypeM = 32'h08;
    want("abort_ste", STE, 0); want("abort_busy_now", BSY, 1);
    check_all();
    tick();
    excepttypeM = 0;
    want("abort_busy", BSY, 0); want("abort_ste_next", STE, 0);
    check_all();

    // reset mid-divide, new start accepted right after release
    div_startE = 1;
    tick();
    div_startE = 0;
    tick();
    rst = 0;
    want("rstdiv_busy", BSY, 0);
    check_all();
    tick();
    rst = 1; div_startE = 1;
    want("restart_ste", STE, 1);
    check_all();
    tick();
    div_startE = 0;
    want("restart_busy", BSY, 1);
    check_all();

    // saturating stall counter with CNTW=4
    do_reset();
    memtoregE = 1; writeregE = 5; rtD = 5;
    repeat (5) tick();
    want("cnt5", CNT, 5);
    check_all();
    repeat (15) tick();
    want("cnt_sat", CNT, 15);
    check_all();
    rst = 0;
    want("cnt_rst", CNT, 0);
    check_all();
    clr_inputs();
    tick();
    rst = 1;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
